inta_sequencer: RTL and testbench
=================================

// Module: inta_sequencer
// PURPOSE
//  Clocked interrupt-acknowledge sequencer for the 8259A PIC. It tracks the two-pulse 8086 INTA cycle,
//  freezes the winning IRQ, and drives the cascade lines (master) or decodes them (slave).
//  It decides which device drives the vector on the second pulse and emits ISR-set/IRR-clear strobes.
//  Sits between the priority resolver / control logic and the CAS pins and data-bus buffer.
// PARAMETERS
//  SYNC_STAGES  2    flops in the INTA_n synchronizer (>=2)
//  TIMEOUT      255  cycles allowed between INTA pulses before abort (1..255)
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  reset        in   1  synchronous, active-high reset
//  INTA_n       in   1  CPU interrupt acknowledge, asynchronous, active-low
//  SP           in   1  1=MASTER, 0=SLAVE
//  SNGL         in   1  1=single PIC, no cascade
//  ICW2         in   8  vector base; only [7:3] used
//  ICW3         in   8  master: slave-present mask per IRQ; slave: [2:0]=own ID
//  irq_valid    in   1  priority resolver has a pending winner
//  irq_id       in   3  winning IRQ number
//  CAS_in       in   3  sampled cascade lines (slave)
//  CAS_out      out  3  cascade ID driven (master)
//  CAS_oe       out  1  enable for CAS_out
//  data_out     out  8  interrupt vector
//  data_oe      out  1  enable for data_out
//  isr_set      out  1  1-cycle pulse: set ISR bit ack_irq, clear its IRR bit
//  ack_irq      out  3  IRQ frozen at first INTA
//  abort        out  1  1-cycle pulse on timeout
// BEHAVIOUR
//  - INTA_n passes through SYNC_STAGES flops. fall = sync high->low, rise = sync low->high, one cycle each.
//  - Reset: all outputs 0, state IDLE, counter 0. Reset in any state returns to IDLE next cycle.
//    Reset releases CAS_oe/data_oe immediately and suppresses pending pulses.
//  - FSM states: IDLE, ACK1, GAP, ACK2.
//    - IDLE: on fall -> ACK1.
//      - Freeze ack_irq = irq_valid ? irq_id : 3'd7 (spurious -> IRQ7). Pulse isr_set only if irq_valid.
//      - Master and !SNGL: CAS_out=ack_irq, CAS_oe=1 from the cycle after fall.
//      - Slave: sel = (CAS_in == ICW3[2:0]), registered on the cycle after fall.
//    - ACK1: on rise -> GAP, counter cleared.
//    - GAP: counter += 1 per cycle. Next fall -> ACK2.
//      - If the counter reaches TIMEOUT with no fall: pulse abort, -> IDLE, CAS_oe=0.
//      - fall in the same cycle as the timeout: fall wins.
//    - ACK2: data_out = {ICW2[7:3], ack_irq}. data_oe=1 while in ACK2 if any of:
//      - SP & SNGL
//      - SP & !SNGL & !ICW3[ack_irq]
//      - !SP & sel
//    - ACK2, master with ICW3[ack_irq]=1: data_oe=0 (the slave drives the vector).
//    - ACK2 on rise -> IDLE. data_oe and CAS_oe drop the same cycle as the transition to IDLE. sel cleared.
//  - Slave never drives CAS: CAS_oe stays 0 when SP=0.
//  - Latency: fall edge at pin -> state change after SYNC_STAGES+1 clocks.
//  - SP/SNGL/ICW changes mid-sequence are ignored. Values are sampled at the IDLE->ACK1 transition.
//  - ack_irq holds until the next ACK1 entry.
// TESTING
//  1. SP=1,SNGL=1,ICW2=0x40,irq_id=5 valid, two INTA pulses:
//     -> isr_set once, ack_irq=5, data_out=0x45 with data_oe=1 only during 2nd pulse, CAS_oe=0.
//  2. SP=1,SNGL=0,ICW3=0x08,irq_id=3: -> CAS_out=3,CAS_oe=1 both pulses; data_oe stays 0.
//     Repeat irq_id=2: -> data_oe=1, data_out={ICW2[7:3],3'd2}.
//  3. SP=0,ICW3=0x03,ICW2=0x70,irq_id=1, CAS_in=3 at 1st INTA -> data_out=0x71 on 2nd pulse.
//     CAS_in=4 -> data_oe never asserts.
//  4. irq_valid=0 at 1st INTA, SP=1,SNGL=1,ICW2=0x08 -> no isr_set, data_out=0x0F on 2nd pulse.
//  5. TIMEOUT=10, single INTA pulse only -> abort pulses 10 cycles after rise, state IDLE, CAS_oe=0.
//     Then assert reset during ACK2 -> next cycle data_oe=0, state IDLE.

Source files
------------

// File: rtl/inta_sequencer.sv
// inta_sequencer: tracks the two-pulse 8086 INTA cycle for an 8259A PIC.
// Freezes the winning IRQ on the first pulse, drives or decodes the cascade
// lines, and decides who places the vector on the data bus during the second
// pulse. Emits one-cycle ISR-set and timeout-abort strobes.
module inta_sequencer #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       INTA_n,
   input  logic       SP,
   input  logic       SNGL,
   input  logic [7:0] ICW2,
   input  logic [7:0] ICW3,
   input  logic       irq_valid,
   input  logic [2:0] irq_id,
   input  logic [2:0] CAS_in,
   output logic [2:0] CAS_out,
   output logic       CAS_oe,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       isr_set,
   output logic [2:0] ack_irq,
   output logic       abort
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACK1 = 2'd1,
      S_GAP  = 2'd2,
      S_ACK2 = 2'd3
   } state_t;

   // Last count value spent in GAP before giving up on the second pulse.
   localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sync_q;
   logic [7:0]             r_cnt;

   // Configuration frozen at the IDLE->ACK1 transition.
   logic                   r_sp;
   logic                   r_sngl;
   logic [4:0]             r_icw2_hi;
   logic [7:0]             r_icw3;
   logic                   r_sel;

   logic [2:0]             r_cas_out;
   logic                   r_cas_oe;
   logic [7:0]             r_data_out;
   logic                   r_data_oe;
   logic                   r_isr_set;
   logic [2:0]             r_ack_irq;
   logic                   r_abort;

   logic                   w_inta_s;
   logic                   w_fall;
   logic                   w_rise;
   logic [2:0]             w_ack;
   logic                   w_drive;
   logic                   w_unused_icw2;

   assign w_inta_s      = r_sync[SYNC_STAGES-1];
   assign w_fall        = r_sync_q & ~w_inta_s;
   assign w_rise        = ~r_sync_q & w_inta_s;
   assign w_ack         = irq_valid ? irq_id : 3'd7;
   assign w_unused_icw2 = &{1'b0, ICW2[2:0]};

   // This device owns the vector: single master, master with no slave on
   // the acknowledged line, or a slave whose ID matched the cascade code.
   assign w_drive = (r_sp & r_sngl)
                  | (r_sp & ~r_sngl & ~r_icw3[r_ack_irq])
                  | (~r_sp & r_sel);

   assign CAS_out  = r_cas_out;
   assign CAS_oe   = r_cas_oe;
   assign data_out = r_data_out;
   assign data_oe  = r_data_oe;
   assign isr_set  = r_isr_set;
   assign ack_irq  = r_ack_irq;
   assign abort    = r_abort;

   // INTA_n synchronizer, edge detect and acknowledge-cycle state machine.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_sync     <= '1;
         r_sync_q   <= 1'b1;
         r_cnt      <= '0;
         r_sp       <= 1'b0;
         r_sngl     <= 1'b0;
         r_icw2_hi  <= '0;
         r_icw3     <= '0;
         r_sel      <= 1'b0;
         r_cas_out  <= '0;
         r_cas_oe   <= 1'b0;
         r_data_out <= '0;
         r_data_oe  <= 1'b0;
         r_isr_set  <= 1'b0;
         r_ack_irq  <= '0;
         r_abort    <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], INTA_n};
         r_sync_q  <= w_inta_s;
         r_isr_set <= 1'b0;
         r_abort   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_state   <= S_ACK1;
                  r_ack_irq <= w_ack;
                  r_isr_set <= irq_valid;
                  r_sp      <= SP;
                  r_sngl    <= SNGL;
                  r_icw2_hi <= ICW2[7:3];
                  r_icw3    <= ICW3;
                  r_sel     <= ~SP & (CAS_in == ICW3[2:0]);
                  r_cas_oe  <= SP & ~SNGL;
                  if (SP & ~SNGL) begin
                     r_cas_out <= w_ack;
                  end
               end
            end
            S_ACK1: begin
               if (w_rise) begin
                  r_state <= S_GAP;
                  r_cnt   <= '0;
               end
            end
            S_GAP: begin
               // A fall arriving on the timeout cycle still completes the cycle.
               if (w_fall) begin
                  r_state    <= S_ACK2;
                  r_data_out <= {r_icw2_hi, r_ack_irq};
                  r_data_oe  <= w_drive;
               end else if (r_cnt == LP_CNT_LAST) begin
                  r_state  <= S_IDLE;
                  r_abort  <= 1'b1;
                  r_cas_oe <= 1'b0;
                  r_sel    <= 1'b0;
                  r_cnt    <= '0;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_ACK2: begin
               if (w_rise) begin
                  r_state   <= S_IDLE;
                  r_data_oe <= 1'b0;
                  r_cas_oe  <= 1'b0;
                  r_sel     <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: drives INTA sequences in master, cascade-master,
// slave and spurious configurations, scores isr_set/vector/abort events
// against a queue of expected events, and checks a reset during ACK2.
module tb_inta_sequencer;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned TIMEOUT     = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic       INTA_n;
   logic       SP;
   logic       SNGL;
   logic [7:0] ICW2;
   logic [7:0] ICW3;
   logic       irq_valid;
   logic [2:0] irq_id;
   logic [2:0] CAS_in;
   logic [2:0] CAS_out;
   logic       CAS_oe;
   logic [7:0] data_out;
   logic       data_oe;
   logic       isr_set;
   logic [2:0] ack_irq;
   logic       abort;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Event kinds: 0 = isr_set (value ack_irq), 1 = vector (data_out), 2 = abort
   typedef struct {
      int unsigned kind;
      logic [7:0]  val;
   } ev_t;

   ev_t  sb[$];
   logic prev_oe = 1'b0;

   inta_sequencer #(
      .SYNC_STAGES(SYNC_STAGES),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .INTA_n   (INTA_n),
      .SP       (SP),
      .SNGL     (SNGL),
      .ICW2     (ICW2),
      .ICW3     (ICW3),
      .irq_valid(irq_valid),
      .irq_id   (irq_id),
      .CAS_in   (CAS_in),
      .CAS_out  (CAS_out),
      .CAS_oe   (CAS_oe),
      .data_out (data_out),
      .data_oe  (data_oe),
      .isr_set  (isr_set),
      .ack_irq  (ack_irq),
      .abort    (abort)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input int unsigned kind, input logic [7:0] val);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      sb.push_back(e);
   endtask

   task automatic pop(input int unsigned kind, input logic [7:0] val);
      ev_t e;
      if (sb.size() == 0) begin
         chk("sb_unexpected_event", kind, 32'hFF);
      end else begin
         e = sb.pop_front();
         chk("sb_kind", kind, e.kind);
         chk("sb_val", val, e.val);
      end
   endtask

   // Output monitor: each DUT event is matched against the scoreboard head.
   always @(negedge clk) begin
      if (!reset) begin
         if (isr_set) pop(0, {5'd0, ack_irq});
         if (data_oe && !prev_oe) pop(1, data_out);
         if (abort) pop(2, 8'd0);
      end
      prev_oe = data_oe;
   end

   task automatic cyc(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One full two-pulse INTA cycle. Configuration inputs are scrambled after
   // the first pulse to show they are frozen at ACK1 entry.
   task automatic do_inta(input logic exp_cas_oe, input logic [2:0] exp_cas,
                          input logic exp_doe, input logic [7:0] exp_vec,
                          input logic exp_isr, input logic [2:0] exp_ack);
      logic       s_sp, s_sngl, s_valid;
      logic [7:0] s_icw2, s_icw3;
      logic [2:0] s_id, s_cas;
      if (exp_isr) push(0, {5'd0, exp_ack});
      if (exp_doe) push(1, exp_vec);
      INTA_n = 1'b0;
      cyc(6);
      chk("p1_cas_oe", CAS_oe, exp_cas_oe);
      if (exp_cas_oe) chk("p1_cas_out", CAS_out, exp_cas);
      chk("p1_data_oe", data_oe, 1'b0);
      chk("p1_ack_irq", ack_irq, exp_ack);
      s_sp = SP; s_sngl = SNGL; s_valid = irq_valid;
      s_icw2 = ICW2; s_icw3 = ICW3; s_id = irq_id; s_cas = CAS_in;
      SP = ~SP; SNGL = ~SNGL; irq_valid = ~irq_valid;
      ICW2 = ~ICW2; ICW3 = ~ICW3; irq_id = ~irq_id; CAS_in = ~CAS_in;
      INTA_n = 1'b1;
      cyc(6);
      INTA_n = 1'b0;
      cyc(6);
      chk("p2_data_oe", data_oe, exp_doe);
      if (exp_doe) chk("p2_data_out", data_out, exp_vec);
      chk("p2_cas_oe", CAS_oe, exp_cas_oe);
      if (exp_cas_oe) chk("p2_cas_out", CAS_out, exp_cas);
      INTA_n = 1'b1;
      cyc(6);
      chk("end_data_oe", data_oe, 1'b0);
      chk("end_cas_oe", CAS_oe, 1'b0);
      chk("end_ack_hold", ack_irq, exp_ack);
      SP = s_sp; SNGL = s_sngl; irq_valid = s_valid;
      ICW2 = s_icw2; ICW3 = s_icw3; irq_id = s_id; CAS_in = s_cas;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n;
      reset = 1'b1; INTA_n = 1'b1; SP = 1'b1; SNGL = 1'b1;
      ICW2 = 8'h00; ICW3 = 8'h00; irq_valid = 1'b0; irq_id = 3'd0; CAS_in = 3'd0;
      cyc(3);
      chk("rst_cas_oe", CAS_oe, 1'b0);
      chk("rst_data_oe", data_oe, 1'b0);
      chk("rst_isr_set", isr_set, 1'b0);
      chk("rst_ack_irq", ack_irq, 3'd0);
      chk("rst_abort", abort, 1'b0);
      chk("rst_data_out", data_out, 8'h00);
      reset = 1'b0;
      cyc(3);

      // Single master
      SP = 1'b1; SNGL = 1'b1; ICW2 = 8'h40; irq_valid = 1'b1; irq_id = 3'd5;
      do_inta(1'b0, 3'd0, 1'b1, 8'h45, 1'b1, 3'd5);

      // Cascade master, slave on IRQ3 then none on IRQ2
      SP = 1'b1; SNGL = 1'b0; ICW3 = 8'h08; irq_id = 3'd3;
      do_inta(1'b1, 3'd3, 1'b0, 8'h00, 1'b1, 3'd3);
      irq_id = 3'd2;
      do_inta(1'b1, 3'd2, 1'b1, 8'h42, 1'b1, 3'd2);

      // Slave: matching then non-matching cascade ID
      SP = 1'b0; SNGL = 1'b0; ICW3 = 8'h03; ICW2 = 8'h70; irq_id = 3'd1; CAS_in = 3'd3;
      do_inta(1'b0, 3'd0, 1'b1, 8'h71, 1'b1, 3'd1);
      CAS_in = 3'd4;
      do_inta(1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 3'd1);

      // Spurious acknowledge -> IRQ7, no ISR strobe
      SP = 1'b1; SNGL = 1'b1; ICW2 = 8'h08; irq_valid = 1'b0; irq_id = 3'd2;
      do_inta(1'b0, 3'd0, 1'b1, 8'h0F, 1'b0, 3'd7);

      // Timeout: only one pulse, cascade master so CAS_oe must drop on abort
      SP = 1'b1; SNGL = 1'b0; ICW3 = 8'h00; irq_valid = 1'b1; irq_id = 3'd4;
      push(0, 8'd4);
      INTA_n = 1'b0;
      cyc(6);
      chk("to_cas_oe_on", CAS_oe, 1'b1);
      push(2, 8'd0);
      INTA_n = 1'b1;
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (abort) break;
      end
      chk("to_abort_latency", n, SYNC_STAGES + 1 + TIMEOUT);
      chk("to_cas_oe_off", CAS_oe, 1'b0);
      cyc(2);
      chk("to_abort_single", abort, 1'b0);
      chk("to_ack_hold", ack_irq, 3'd4);

      // Reset during ACK2
      SP = 1'b1; SNGL = 1'b1; ICW2 = 8'h08; irq_valid = 1'b1; irq_id = 3'd6;
      push(0, 8'd6);
      push(1, 8'h0E);
      INTA_n = 1'b0;
      cyc(6);
      INTA_n = 1'b1;
      cyc(6);
      INTA_n = 1'b0;
      cyc(6);
      chk("ack2_data_oe", data_oe, 1'b1);
      reset = 1'b1;
      INTA_n = 1'b1;
      cyc(1);
      chk("rst_ack2_data_oe", data_oe, 1'b0);
      chk("rst_ack2_ack_irq", ack_irq, 3'd0);
      chk("rst_ack2_data_out", data_out, 8'h00);
      reset = 1'b0;
      cyc(4);

      // Back in IDLE: a fresh sequence must work normally
      SP = 1'b1; SNGL = 1'b1; ICW2 = 8'hA8; irq_valid = 1'b1; irq_id = 3'd0;
      do_inta(1'b0, 3'd0, 1'b1, 8'hA8, 1'b1, 3'd0);

      cyc(4);
      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
